// File: rtl/lru_age_tracker.sv
// True-LRU age tracker: per-way age permutation, max-age victim select via comparator tree.
// Optional invalid-way-first replacement is enabled by defining LRU_INVALID_FIRST_EN.
module lru_age_tracker #(
    parameter int WAYS  = 4,
    parameter int AGE_W = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    acc_valid,
    input  logic [AGE_W-1:0]        acc_way,
    input  logic                    inv_valid,
    input  logic [AGE_W-1:0]        inv_way,
    output logic [AGE_W-1:0]        victim_way,
    output logic [AGE_W-1:0]        hit_age,
    output logic [WAYS*AGE_W-1:0]   ages_o
);

    logic [AGE_W-1:0] age_reg  [WAYS];
    logic [AGE_W-1:0] age_next [WAYS];
    logic [AGE_W-1:0] acc_old_age;
    logic [AGE_W-1:0] inv_old_age;
    logic             inv_apply;
    logic [AGE_W-1:0] max_way;
    logic [AGE_W-1:0] victim_next;

    assign acc_old_age = age_reg[acc_way];
    assign inv_old_age = age_reg[inv_way];
    // An access in the same cycle always wins over an invalidate.
    assign inv_apply   = inv_valid & ~acc_valid;

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_age
            assign age_next[gi] =
                acc_valid ? ((acc_way == AGE_W'(gi))        ? '0 :
                             (age_reg[gi] < acc_old_age)    ? age_reg[gi] + AGE_W'(1) :
                                                              age_reg[gi]) :
                inv_apply ? ((inv_way == AGE_W'(gi))        ? AGE_W'(WAYS-1) :
                             (age_reg[gi] > inv_old_age)    ? age_reg[gi] - AGE_W'(1) :
                                                              age_reg[gi]) :
                            age_reg[gi];
            assign ages_o[gi*AGE_W +: AGE_W] = age_reg[gi];
        end
    endgenerate

    // Heap-ordered comparator tree: leaves WAYS-1.. hold ways 0..WAYS-1, node 0 is the root.
    // The left subtree always holds lower indices, so the right child wins only when strictly older.
    logic [AGE_W-1:0] node_age [2*WAYS-1];
    logic [AGE_W-1:0] node_idx [2*WAYS-1];

    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_leaf
            assign node_age[WAYS-1+gi] = age_next[gi];
            assign node_idx[WAYS-1+gi] = AGE_W'(gi);
        end
        for (gi = 0; gi < WAYS-1; gi++) begin : g_node
            logic right_wins;
            assign right_wins    = node_age[2*gi+2] > node_age[2*gi+1];
            assign node_age[gi]  = right_wins ? node_age[2*gi+2] : node_age[2*gi+1];
            assign node_idx[gi]  = right_wins ? node_idx[2*gi+2] : node_idx[2*gi+1];
        end
    endgenerate

    assign max_way = node_idx[0];

`ifdef LRU_INVALID_FIRST_EN
    localparam logic [AGE_W-1:0] VICTIM_RST = '0;

    logic [WAYS-1:0]  valid_reg;
    logic [WAYS-1:0]  valid_next;
    logic             any_invalid;
    logic [AGE_W-1:0] first_invalid;

    always_comb begin
        valid_next = valid_reg;
        if (acc_valid) begin
            valid_next[acc_way] = 1'b1;
        end else if (inv_apply) begin
            valid_next[inv_way] = 1'b0;
        end
    end

    // Scan downwards so the lowest invalid index is the last one written.
    always_comb begin
        any_invalid   = 1'b0;
        first_invalid = '0;
        for (int i = WAYS-1; i >= 0; i--) begin
            if (!valid_next[i]) begin
                any_invalid   = 1'b1;
                first_invalid = AGE_W'(i);
            end
        end
    end

    assign victim_next = any_invalid ? first_invalid : max_way;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
        end else begin
            valid_reg <= valid_next;
        end
    end
`else
    localparam logic [AGE_W-1:0] VICTIM_RST = AGE_W'(WAYS-1);

    assign victim_next = max_way;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WAYS; i++) begin
                age_reg[i] <= AGE_W'(i);
            end
            victim_way <= VICTIM_RST;
            hit_age    <= '0;
        end else begin
            for (int i = 0; i < WAYS; i++) begin
                age_reg[i] <= age_next[i];
            end
            victim_way <= victim_next;
            if (acc_valid) begin
                hit_age <= acc_old_age;
            end
        end
    end

endmodule

// File: tb/tb_lru_age_tracker.sv
// Randomized self-checking bench for lru_age_tracker against a plain-array LRU model.
// Honours LRU_INVALID_FIRST_EN to match the build of the design.
module tb_lru_age_tracker;

    localparam int WAYS  = 4;
    localparam int AGE_W = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic                  acc_valid = 1'b0;
    logic [AGE_W-1:0]      acc_way = '0;
    logic                  inv_valid = 1'b0;
    logic [AGE_W-1:0]      inv_way = '0;
    logic [AGE_W-1:0]      victim_way;
    logic [AGE_W-1:0]      hit_age;
    logic [WAYS*AGE_W-1:0] ages_o;

    lru_age_tracker #(.WAYS(WAYS), .AGE_W(AGE_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .acc_valid  (acc_valid),
        .acc_way    (acc_way),
        .inv_valid  (inv_valid),
        .inv_way    (inv_way),
        .victim_way (victim_way),
        .hit_age    (hit_age),
        .ages_o     (ages_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Reference model: recency rank per way, valid flags, last hit age.
    int m_age [WAYS];
    bit m_valid [WAYS];
    int m_hit;

    function automatic int m_victim();
        int best;
`ifdef LRU_INVALID_FIRST_EN
        for (int i = 0; i < WAYS; i++) begin
            if (!m_valid[i]) return i;
        end
`endif
        best = 0;
        for (int i = 1; i < WAYS; i++) begin
            if (m_age[i] > m_age[best]) best = i;
        end
        return best;
    endfunction

    function automatic int dut_age(int i);
        return int'(ages_o[i*AGE_W +: AGE_W]);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < WAYS; i++) begin
            m_age[i]   = i;
            m_valid[i] = 1'b0;
        end
        m_hit = 0;
    endtask

    task automatic model_access(input int w);
        int a;
        a = m_age[w];
        m_hit = a;
        for (int i = 0; i < WAYS; i++) begin
            if (i == w) m_age[i] = 0;
            else if (m_age[i] < a) m_age[i] = m_age[i] + 1;
        end
        m_valid[w] = 1'b1;
    endtask

    task automatic model_invalidate(input int w);
        int a;
        a = m_age[w];
        for (int i = 0; i < WAYS; i++) begin
            if (i == w) m_age[i] = WAYS - 1;
            else if (m_age[i] > a) m_age[i] = m_age[i] - 1;
        end
        m_valid[w] = 1'b0;
    endtask

    // One compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        if (check_en) begin
            for (int i = 0; i < WAYS; i++) begin
                chk($sformatf("age%0d", i), dut_age(i), m_age[i]);
            end
            chk("victim_way", int'(victim_way), m_victim());
            chk("hit_age", int'(hit_age), m_hit);
        end
    end

    // Called one time unit after a rising edge; returns at the same phase.
    task automatic step(input bit av, input int aw, input bit iv, input int iw);
        acc_valid = av;
        acc_way   = AGE_W'(aw);
        inv_valid = iv;
        inv_way   = AGE_W'(iw);
        @(posedge clk);
        if (av) model_access(aw);
        else if (iv) model_invalidate(iw);
        #1;
        acc_valid = 1'b0;
        inv_valid = 1'b0;
        $display("txn acc=%0d/%0d inv=%0d/%0d ages=%0d,%0d,%0d,%0d victim=%0d hit=%0d",
                 av, aw, iv, iw, m_age[0], m_age[1], m_age[2], m_age[3], m_victim(), m_hit);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        $display("txn reset");
    endtask

    task automatic chk_ages(input string tag, input int a0, input int a1, input int a2, input int a3);
        chk({tag, "_age0"}, dut_age(0), a0);
        chk({tag, "_age1"}, dut_age(1), a1);
        chk({tag, "_age2"}, dut_age(2), a2);
        chk({tag, "_age3"}, dut_age(3), a3);
    endtask

    initial begin
        model_reset();
        #1;
        rst_n    = 1'b0;
        check_en = 1'b1;
        #1;
        chk_ages("rst", 0, 1, 2, 3);
        chk("rst_hit", int'(hit_age), 0);
`ifdef LRU_INVALID_FIRST_EN
        chk("rst_victim", int'(victim_way), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 0, 1'b0, 0);
        chk("inv1st_victim_a", int'(victim_way), 1);
        step(1'b1, 1, 1'b0, 0);
        step(1'b1, 2, 1'b0, 0);
        step(1'b1, 3, 1'b0, 0);
        chk_ages("inv1st_full", 3, 2, 1, 0);
        chk("inv1st_victim_b", int'(victim_way), 0);
        step(1'b0, 0, 1'b1, 2);
        chk("inv1st_victim_c", int'(victim_way), 2);
`else
        chk("rst_victim", int'(victim_way), 3);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 3, 1'b0, 0);
        chk_ages("acc3", 1, 2, 3, 0);
        chk("acc3_victim", int'(victim_way), 2);
        chk("acc3_hit", int'(hit_age), 3);
        step(1'b1, 1, 1'b0, 0);
        chk_ages("acc1", 2, 0, 3, 1);
        chk("acc1_victim", int'(victim_way), 2);
        chk("acc1_hit", int'(hit_age), 2);
        step(1'b0, 0, 1'b1, 0);
        chk_ages("inv0", 3, 0, 2, 1);
        chk("inv0_victim", int'(victim_way), 0);
        chk("inv0_hit_hold", int'(hit_age), 2);
        step(1'b1, 1, 1'b0, 0);
        chk_ages("acc_mru", 3, 0, 2, 1);
        chk("acc_mru_hit", int'(hit_age), 0);
        do_reset();
        step(1'b1, 2, 1'b1, 1);
        chk_ages("both", 1, 2, 0, 3);
        chk("both_victim", int'(victim_way), 3);
        do_reset();
        step(1'b1, 3, 1'b0, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_ages("async_rst", 0, 1, 2, 3);
        chk("async_rst_victim", int'(victim_way), 3);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
`endif
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 1)), int'($urandom_range(0, WAYS-1)),
                     1'($urandom_range(0, 1)), int'($urandom_range(0, WAYS-1)));
            end
        end
        // Directed edges: invalidate of the oldest way and simultaneous strobes on one way.
        step(1'b0, 0, 1'b1, m_victim());
        step(1'b1, 1, 1'b1, 1);
        step(1'b0, 0, 1'b0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
